// File: rtl/lamp_conflict_monitor_pkg.sv
// traffic_lamp_pkg: shared lamp encoding, controller state encoding and
// fault-class bit positions for the lamp output stage and its checkers.
// Ports: none (package only).
package traffic_lamp_pkg;

   // Lamp vector bit positions
   localparam int MAIN_R = 6;
   localparam int MAIN_Y = 5;
   localparam int MAIN_G = 4;
   localparam int SIDE_R = 3;
   localparam int SIDE_Y = 2;
   localparam int SIDE_G = 1;
   localparam int WALK   = 0;

   localparam logic [6:0] ALL_RED = 7'b1001000;

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_NORMAL  = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   // fault_code bit positions: {c2,c1,c0}
   localparam int FC_C0 = 0;   // a direction is not exactly one of R/Y/G
   localparam int FC_C1 = 1;   // both directions non-red
   localparam int FC_C2 = 2;   // walk while any direction non-red

   // Flashing all-red pattern; phase=1 lights both reds
   function automatic logic [6:0] flash_pattern(input logic phase);
      return {phase, 2'b00, phase, 3'b000};
   endfunction

endpackage

// File: rtl/lamp_conflict_monitor_check.sv
// lamp_conflict_check: purely combinational classifier of a lamp vector into
// conflict classes {c2,c1,c0}.
// Ports: leds (7-bit lamp vector in), cls (3-bit conflict classes out).
module lamp_conflict_check
   import traffic_lamp_pkg::*;
(
   input  logic [6:0] leds,
   output logic [2:0] cls
);

   logic main_one_hot;
   logic side_one_hot;
   logic main_non_red;
   logic side_non_red;

   // Exactly one of three: odd parity excluding the all-three case
   assign main_one_hot = (leds[MAIN_R] ^ leds[MAIN_Y] ^ leds[MAIN_G]) &
                         ~(leds[MAIN_R] & leds[MAIN_Y] & leds[MAIN_G]);
   assign side_one_hot = (leds[SIDE_R] ^ leds[SIDE_Y] ^ leds[SIDE_G]) &
                         ~(leds[SIDE_R] & leds[SIDE_Y] & leds[SIDE_G]);

   // Non-red means any amber or green aspect is lit
   assign main_non_red = leds[MAIN_Y] | leds[MAIN_G];
   assign side_non_red = leds[SIDE_Y] | leds[SIDE_G];

   always_comb begin
      cls        = 3'b000;
      cls[FC_C0] = ~main_one_hot | ~side_one_hot;
      cls[FC_C1] = main_non_red & side_non_red;
      cls[FC_C2] = leds[WALK] & (main_non_red | side_non_red);
   end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor: lamp output stage behind the traffic FSM. Holds
// all-red for a startup interval, passes legal vectors with one cycle of
// latency, holds the last good vector on conflict, and latches a flashing
// all-red fault after FAULT_PERSIST consecutive conflicting cycles.
// Ports: clk, Reset_Sync (sync active-high), oneHz_enable (tick), LEDs_in[6:0]
//        -> lamps[6:0], fault, fault_code[2:0] (all registered).
module lamp_conflict_monitor
   import traffic_lamp_pkg::*;
#(
   parameter int STARTUP_TICKS    = 3,
   parameter int FAULT_PERSIST    = 2,
   parameter int FLASH_HALF_TICKS = 1
)(
   input  logic       clk,
   input  logic       Reset_Sync,
   input  logic       oneHz_enable,
   input  logic [6:0] LEDs_in,
   output logic [6:0] lamps,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam int TW = 8;

   state_t        state, state_nx;
   logic [3:0]    persist, persist_nx;
   logic [TW-1:0] tick_cnt, tick_nx;
   logic          phase, phase_nx;
   logic [6:0]    lamps_nx;
   logic          fault_nx;
   logic [2:0]    code_nx;
   logic [2:0]    cls;
   logic          conflict;
   logic          trip;

   lamp_conflict_check u_check (
      .leds (LEDs_in),
      .cls  (cls)
   );

   assign conflict = |cls;
   // FAULT is latched, so conflicts there are irrelevant
   assign trip = conflict && (persist == 4'(FAULT_PERSIST - 1)) && (state != ST_FAULT);

   always_ff @(posedge clk) begin
      if (Reset_Sync) begin
         state      <= ST_STARTUP;
         lamps      <= ALL_RED;
         fault      <= 1'b0;
         fault_code <= 3'b000;
         persist    <= 4'd0;
         tick_cnt   <= '0;
         phase      <= 1'b0;
      end else begin
         state      <= state_nx;
         lamps      <= lamps_nx;
         fault      <= fault_nx;
         fault_code <= code_nx;
         persist    <= persist_nx;
         tick_cnt   <= tick_nx;
         phase      <= phase_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      lamps_nx   = lamps;
      fault_nx   = fault;
      code_nx    = fault_code;
      tick_nx    = tick_cnt;
      phase_nx   = phase;
      persist_nx = 4'd0;

      if (state != ST_FAULT && conflict)
         persist_nx = (persist == 4'hF) ? persist : persist + 4'd1;

      case (state)
         ST_STARTUP: begin
            lamps_nx = ALL_RED;
            if (STARTUP_TICKS == 0) begin
               state_nx = ST_NORMAL;
            end else if (oneHz_enable) begin
               if (tick_cnt == TW'(STARTUP_TICKS - 1)) begin
                  state_nx = ST_NORMAL;
                  tick_nx  = '0;
               end else begin
                  tick_nx = tick_cnt + 1'b1;
               end
            end
         end
         ST_NORMAL: begin
            // Conflicting requests never reach the lamps: keep last good
            if (!conflict)
               lamps_nx = LEDs_in;
         end
         ST_FAULT: begin
            if (oneHz_enable) begin
               if (tick_cnt == TW'(FLASH_HALF_TICKS - 1)) begin
                  phase_nx = ~phase;
                  tick_nx  = '0;
               end else begin
                  tick_nx = tick_cnt + 1'b1;
               end
            end
            lamps_nx = flash_pattern(phase_nx);
         end
         default: begin
            state_nx = ST_FAULT;
            fault_nx = 1'b1;
            phase_nx = 1'b1;
            tick_nx  = '0;
            lamps_nx = flash_pattern(1'b1);
         end
      endcase

      // Trip overrides startup completion; a coincident tick is discarded
      if (trip) begin
         state_nx = ST_FAULT;
         fault_nx = 1'b1;
         code_nx  = cls;
         phase_nx = 1'b1;
         tick_nx  = '0;
         lamps_nx = flash_pattern(1'b1);
      end
   end

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Scoreboard bench for lamp_conflict_monitor: stimulus pushes expected
// outputs tagged with the cycle they must appear in; a negedge monitor
// pops and compares. A second instance covers STARTUP_TICKS=0.
module tb_lamp_conflict_monitor;

   localparam logic [6:0] AR = 7'b1001000;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [6:0] leds;
   logic [6:0] lamps_a, lamps_b;
   logic       fault_a, fault_b;
   logic [2:0] code_a, code_b;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

   typedef struct {
      int         cyc;
      int         inst;
      logic [6:0] lamps;
      logic       fault;
      logic [2:0] code;
      string      name;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lamp_conflict_monitor #(.STARTUP_TICKS(3), .FAULT_PERSIST(2), .FLASH_HALF_TICKS(1)) dut (
      .clk          (clk),
      .Reset_Sync   (rst),
      .oneHz_enable (tick),
      .LEDs_in      (leds),
      .lamps        (lamps_a),
      .fault        (fault_a),
      .fault_code   (code_a)
   );

   lamp_conflict_monitor #(.STARTUP_TICKS(0), .FAULT_PERSIST(2), .FLASH_HALF_TICKS(1)) dut0 (
      .clk          (clk),
      .Reset_Sync   (rst),
      .oneHz_enable (tick),
      .LEDs_in      (leds),
      .lamps        (lamps_b),
      .fault        (fault_b),
      .fault_code   (code_b)
   );

   task automatic expect_at(input int dly, input int inst, input logic [6:0] l,
                            input logic f, input logic [2:0] c, input string name);
      exp_t e;
      e.cyc = cyc + dly;
      e.inst = inst;
      e.lamps = l;
      e.fault = f;
      e.code = c;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due this cycle
   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            logic [6:0] l;
            logic       f;
            logic [2:0] c;
            l = (q[i].inst == 0) ? lamps_a : lamps_b;
            f = (q[i].inst == 0) ? fault_a : fault_b;
            c = (q[i].inst == 0) ? code_a  : code_b;
            checks = checks + 1;
            if (l !== q[i].lamps || f !== q[i].fault || c !== q[i].code) begin
               errors = errors + 1;
               $display("FAIL %s cyc=%0d inst=%0d got lamps=%b fault=%b code=%b want lamps=%b fault=%b code=%b",
                        q[i].name, cyc, q[i].inst, l, f, c, q[i].lamps, q[i].fault, q[i].code);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc || done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s never checked (due cyc=%0d, now %0d)", q[i].name, q[i].cyc, cyc);
            q.delete(i);
         end
      end
   end

   initial begin
      rst  = 1'b1;
      tick = 1'b0;
      leds = 7'b0011000;            // Main G, Side R: legal
      step();
      expect_at(0, 0, AR, 1'b0, 3'b000, "reset_a");
      expect_at(0, 1, AR, 1'b0, 3'b000, "reset_b");
      rst = 1'b0;
      expect_at(1, 0, AR, 1'b0, 3'b000, "startup_hold");
      expect_at(1, 1, AR, 1'b0, 3'b000, "st0_first_cycle");
      expect_at(2, 1, 7'b0011000, 1'b0, 3'b000, "st0_passthru");

      // Startup: tick every 10 cycles; pass-through 2 cycles after 3rd tick
      for (int k = 1; k <= 3; k++) begin
         repeat (9) step();
         tick = 1'b1;
         expect_at(1, 0, AR, 1'b0, 3'b000, "startup_tick");
         if (k == 3)
            expect_at(2, 0, 7'b0011000, 1'b0, 3'b000, "startup_done");
         step();
         tick = 1'b0;
      end
      step();

      // Latency and last-good hold
      leds = 7'b0101000;
      expect_at(1, 0, 7'b0101000, 1'b0, 3'b000, "lat_main_y");
      step();
      leds = 7'b1000010;
      expect_at(1, 0, 7'b1000010, 1'b0, 3'b000, "lat_side_g");
      step();
      leds = 7'b0010010;
      expect_at(1, 0, 7'b1000010, 1'b0, 3'b000, "glitch_hold");
      step();
      leds = 7'b1000010;
      expect_at(1, 0, 7'b1000010, 1'b0, 3'b000, "glitch_recover");
      step();

      // Trip on both-green held two cycles, then flash
      leds = 7'b0010010;
      expect_at(1, 0, 7'b1000010, 1'b0, 3'b000, "trip_first");
      step();
      expect_at(1, 0, AR, 1'b1, 3'b010, "trip_c1");
      step();
      leds = 7'b1000010;
      expect_at(1, 0, AR, 1'b1, 3'b010, "fault_ignores_leds");
      step();
      step();
      tick = 1'b1;
      expect_at(1, 0, 7'b0000000, 1'b1, 3'b010, "flash_off");
      step();
      tick = 1'b0;
      expect_at(1, 0, 7'b0000000, 1'b1, 3'b010, "flash_off_hold");
      step();
      tick = 1'b1;
      expect_at(1, 0, AR, 1'b1, 3'b010, "flash_on");
      step();
      tick = 1'b0;

      // Reset mid-flash, then Main R+Y trips from STARTUP
      rst = 1'b1;
      expect_at(1, 0, AR, 1'b0, 3'b000, "reset_mid_flash");
      step();
      rst = 1'b0;
      leds = 7'b1101000;
      expect_at(1, 0, AR, 1'b0, 3'b000, "c0_first");
      step();
      expect_at(1, 0, AR, 1'b1, 3'b001, "trip_c0_startup");
      step();
      step();

      // Reset, fast startup with walk-on-all-red legal vector
      rst = 1'b1;
      leds = 7'b1001001;
      step();
      rst = 1'b0;
      tick = 1'b1;
      step();
      step();
      expect_at(1, 0, AR, 1'b0, 3'b000, "startup3_last");
      expect_at(2, 0, 7'b1001001, 1'b0, 3'b000, "walk_legal");
      step();
      tick = 1'b0;
      expect_at(1, 0, 7'b1001001, 1'b0, 3'b000, "walk_steady");
      step();

      // Walk with Main green: trip cycle coincides with a tick
      leds = 7'b0011001;
      expect_at(1, 0, 7'b1001001, 1'b0, 3'b000, "c2_first_hold");
      step();
      tick = 1'b1;
      expect_at(1, 0, AR, 1'b1, 3'b100, "trip_c2_tick");
      step();
      tick = 1'b0;
      expect_at(1, 0, AR, 1'b1, 3'b100, "tick_at_trip_ignored");
      step();
      expect_at(1, 0, AR, 1'b1, 3'b100, "no_early_toggle");
      step();
      tick = 1'b1;
      expect_at(1, 0, 7'b0000000, 1'b1, 3'b100, "first_toggle");
      step();
      tick = 1'b0;
      leds = 7'b1000010;

      // Final reset returns to clean state
      rst = 1'b1;
      expect_at(1, 0, AR, 1'b0, 3'b000, "final_reset");
      step();
      rst = 1'b0;
      repeat (3) step();

      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
